rotate_sched: RTL and testbench

- Sequencing controller for the rotating seven-segment LED pattern.
- Turns raw run/direction/speed/step controls into a registered position index (0..7) and a one-cycle step strobe.
- The downstream rotating-LED display datapath consumes these to place the square on the 4-digit display; this block owns all timing and stepping decisions.
- Sits between the board switch/button inputs and the display datapath, in the same top level that wires switches to the rotating display.

---
 rtl/rotate_sched.sv | 134 +++++++++++++
 tb/tb_rotate_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rotate_sched.sv
// Sequencer for the rotating seven-segment pattern: turns run/direction/speed/step
// controls into a registered position index, a one-cycle step strobe and a wrap strobe.
module rotate_sched #(
    parameter int TICK_DIV = 5000000,
    parameter int CNT_W    = 23
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       cw,
    input  logic [1:0] speed,
    input  logic       step_req,
    output logic [2:0] pos,
    output logic       step,
    output logic       wrap,
    output logic       running
);

    // Handshake: none. en/cw/speed are levels sampled every cycle; step_req is a
    // level whose rising edge (vs. the previous sample) requests one advance.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SSTEP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit;
    logic [2:0]       pos_q, pos_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             running_q, running_d;
    logic             req_q;
    logic             req_rise;
    logic             advance;

    // Terminal count for the current speed; a >= compare lets a speed-up mid-count
    // fire on the next cycle instead of running on to counter wrap.
    always_comb begin
        limit = CNT_W'(TICK_DIV >> speed) - CNT_W'(1);
    end

    assign req_rise = step_req & ~req_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (req_rise) begin
                    state_d = ST_SSTEP;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SSTEP: begin
                state_d = en ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        advance = 1'b0;
        cnt_d   = '0;
        case (state_q)
            ST_RUN: begin
                // Dropping en wins over a terminal count: no advance on the way out.
                if (en) begin
                    if (cnt_q >= limit) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SSTEP: begin
                advance = 1'b1;
            end
            default: begin
                advance = 1'b0;
            end
        endcase

        pos_d     = pos_q;
        if (advance) begin
            pos_d = cw ? pos_q + 3'd1 : pos_q - 3'd1;
        end
        step_d    = advance;
        wrap_d    = advance & (cw ? (pos_q == 3'd7) : (pos_q == 3'd0));
        running_d = (state_d == ST_RUN);
    end

    // History resets to 1 so a step_req held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pos_q     <= 3'd0;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
            req_q     <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
            req_q     <= step_req;
        end
    end

    assign pos     = pos_q;
    assign step    = step_q;
    assign wrap    = wrap_q;
    assign running = running_q;

endmodule

// File: tb/tb_rotate_sched.sv
// Directed bench for rotate_sched with TICK_DIV=8; expected values are hand-derived.
module tb_rotate_sched;

    localparam int TICK_DIV = 8;
    localparam int CNT_W    = 4;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       cw;
    logic [1:0] speed;
    logic       step_req;
    logic [2:0] pos;
    logic       step;
    logic       wrap;
    logic       running;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2:0] exp_q[$];

    rotate_sched #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .cw       (cw),
        .speed    (speed),
        .step_req (step_req),
        .pos      (pos),
        .step     (step),
        .wrap     (wrap),
        .running  (running)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ticks until step is seen (bounded); gap = cycles taken, or -1 on timeout.
    task automatic wait_step(input int limit, output int gap);
        gap = -1;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if (step === 1'b1) begin
                gap = n;
                break;
            end
        end
    endtask

    task automatic expect_step(input string tag, input int exp_gap,
                               input logic [2:0] exp_pos, input logic exp_wrap);
        int gap;
        wait_step(40, gap);
        check_eq({tag, "_gap"}, gap, exp_gap);
        check_eq({tag, "_pos"}, pos, exp_pos);
        check_eq({tag, "_wrap"}, wrap, exp_wrap);
    endtask

    initial begin
        int steps_seen;
        logic [2:0] e;

        reset_n  = 1'b0;
        en       = 1'b0;
        cw       = 1'b1;
        speed    = 2'd0;
        step_req = 1'b0;
        #12;
        check_eq("rst_pos", pos, 0);
        check_eq("rst_step", step, 0);
        check_eq("rst_wrap", wrap, 0);
        check_eq("rst_running", running, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Auto-rotate clockwise at speed 0: one step per 8 cycles, wrap on 7->0.
        en = 1'b1;
        tick();
        check_eq("run_start_running", running, 1);
        for (int i = 1; i <= 8; i++) exp_q.push_back(3'(i));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            expect_step("cw_run", 8, e, (e == 3'd0));
        end

        // Counter-clockwise at speed 2: one step per 2 cycles, wrap on 0->7.
        cw    = 1'b0;
        speed = 2'd2;
        expect_step("ccw_s2_a", 2, 7, 1);
        expect_step("ccw_s2_b", 2, 6, 0);
        expect_step("ccw_s2_c", 2, 5, 0);

        // Speed-up mid-count: cnt=5 at speed 0, switch to speed 3 -> advance next cycle.
        cw    = 1'b1;
        speed = 2'd0;
        steps_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (step) steps_seen++;
        end
        check_eq("pre_speedup_nostep", steps_seen, 0);
        speed = 2'd3;
        expect_step("speedup_a", 1, 6, 0);
        expect_step("speedup_b", 1, 7, 0);

        // Drop en in the terminal cycle: no step, pos held.
        speed = 2'd0;
        for (int i = 0; i < 7; i++) tick();
        en = 1'b0;
        tick();
        check_eq("stop_step", step, 0);
        check_eq("stop_running", running, 0);
        check_eq("stop_pos", pos, 7);

        // Re-raise en: first step 8 cycles after running goes high.
        en = 1'b1;
        tick();
        check_eq("restart_running", running, 1);
        expect_step("restart", 8, 0, 1);

        // Single-step mode: one step per rising edge of step_req.
        en = 1'b0;
        tick();
        check_eq("sstep_idle_running", running, 0);
        step_req = 1'b1;
        expect_step("sstep_a", 2, 1, 0);
        steps_seen = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (step) steps_seen++;
        end
        check_eq("sstep_hold_nostep", steps_seen, 0);
        check_eq("sstep_hold_pos", pos, 1);
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        expect_step("sstep_b", 2, 2, 0);
        step_req = 1'b0;

        // Async reset mid-run at pos=5, with step_req held high across release.
        speed = 2'd3;
        en    = 1'b1;
        tick();
        expect_step("to5_a", 1, 3, 0);
        expect_step("to5_b", 1, 4, 0);
        expect_step("to5_c", 1, 5, 0);
        step_req = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_pos", pos, 0);
        check_eq("async_rst_step", step, 0);
        check_eq("async_rst_wrap", wrap, 0);
        check_eq("async_rst_running", running, 0);
        en = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        steps_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (step) steps_seen++;
        end
        check_eq("post_rst_req_nostep", steps_seen, 0);
        check_eq("post_rst_pos", pos, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
